load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the ALU in the RISC-V datapath.
- Takes the ALU Result as the effective address, plus rs2 store data and the funct3 access size.
- Drives a data-memory port that may insert wait states.
- Performs byte-lane steering, sign/zero extension, misalignment checking and a bus timeout, and stalls the core until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles waiting for mem_ready before abort (must be >=2)
- CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- MemRead  input  1  current instruction is a load
- MemWrite  input  1  current instruction is a store
- funct3  input  3  access size/sign (RV32I load/store encoding)
- Addr  input  32  effective address (ALU Result)
- WriteData  input  32  store data (rs2)
- ReadData  output  32  extended load result, valid while done=1
- stall  output  1  freeze PC/pipeline this cycle
- done  output  1  one-cycle pulse, access completed
- err  output  1  one-cycle pulse, misaligned/illegal/timeout
- err_cause  output  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none
- mem_req  output  1  memory request
- mem_we  output  1  1=write
- mem_addr  output  32  word address, {Addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_rdata  input  32  memory read word
- mem_ready  input  1  memory accepts write / returns read data this cycle

Behaviour:
- Reset (async): state=IDLE, all outputs 0, counter 0, latched fields 0.
- start = MemRead|MemWrite, sampled in IDLE only. If both are high, it is treated as illegal.
- stall (combinational) = (IDLE & start) | BUSY.
  - Low in DONE and ERR, so the core commits or traps at the end of those cycles.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE & start:
  - latch we, funct3, Addr, WriteData;
  - if illegal funct3 -> ERR, cause 10;
  - else if misaligned -> ERR, cause 01;
  - else -> BUSY with counter=0.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal store funct3: 000 SB, 001 SH, 010 SW. Everything else is illegal.
  - Misaligned: half with Addr[0]=1; word with Addr[1:0]!=0.
- BUSY:
  - mem_req=1; mem_we/addr/be/wdata driven from latched fields and held stable until mem_ready.
  - mem_ready=1 -> capture mem_rdata, go to DONE.
  - Else counter++. When counter reaches TIMEOUT_CYCLES-1 with no ready -> ERR, cause 11.
  - mem_ready on that same cycle wins (DONE).
- DONE: done=1 for exactly one cycle; ReadData valid (0 for stores); -> IDLE.
- ERR: err=1 and err_cause valid for exactly one cycle; mem_req=0; no memory access ever issued for misaligned/illegal; -> IDLE.
- start is ignored outside IDLE. Latency: a zero-wait memory completes in 2 cycles (BUSY, DONE).
- Byte enables:
  - byte: 4'b0001<<Addr[1:0]
  - half: 4'b0011<<{Addr[1],1'b0}
  - word: 4'b1111
- Store data: byte {4{WD[7:0]}}, half {2{WD[15:0]}}, word WD.
- Load path: shifted = rdata >> (8*Addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unchanged.
- mem_req never asserted outside BUSY. Reset mid-BUSY drops mem_req immediately; the memory must tolerate an abandoned request.

Decomposition:
- Shared package lsu_pkg:
  - funct3 encodings: LB, LH, LW, LBU, LHU, SB, SH, SW
  - err_cause codes
  - state encoding
- One sub-module: lsu_lane_align (combinational). Produces mem_be and mem_wdata from size+offset, and ReadData from rdata+offset+sign. FSM, counter and timeout stay in the top.

Test Plan:
- LW Addr=0x100, mem_ready high on the first BUSY cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111; done on the 2nd cycle; ReadData=0xDEADBEEF; stall high for 1 cycle.
- LB Addr=0x103, rdata=0x80FF_FF_FF -> be=1000, ReadData=0xFFFFFF80. Same access as LBU -> ReadData=0x00000080.
- SH Addr=0x202, WriteData=0x1234ABCD, ready after 3 wait cycles -> mem_we=1, be=1100, wdata=0xABCDABCD held stable 4 cycles; done pulse; stall high for 4 cycles.
- LW Addr=0x101 -> no mem_req; err=1, cause=01 the next cycle. SW with funct3=011 -> err=1, cause=10.
- LW with mem_ready held low -> err=1, cause=11 exactly TIMEOUT_CYCLES cycles after entering BUSY; mem_req deasserts. Repeat with ready on the final count cycle -> done, no err.
- Assert reset during BUSY -> mem_req, stall, done, err go to 0 immediately. After release, a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 access codes, error causes,
// FSM states and small decode helpers.
package lsu_pkg;

    // RV32I load/store funct3 encodings (loads and stores share the size codes)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ErrNone     = 2'b00,
        ErrMisalign = 2'b01,
        ErrIllegal  = 2'b10,
        ErrTimeout  = 2'b11
    } err_cause_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10,
        StErr  = 2'b11
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated store data from size/offset,
// plus shifted and sign/zero-extended load data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Store side: enables and replicated data depend only on size and offset
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend
    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        case (i_funct3)
            F3_LB:   o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  o_rdata = {24'h0, w_shifted[7:0]};
            F3_LHU:  o_rdata = {16'h0, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: latches one access from the core, runs it on the data-memory
// port with a wait-state timeout, and reports completion or error as pulses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_cause,
    load_store_unit_if.master bus
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e  r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic        r_mem_req;
    logic        r_done;
    logic        r_err;
    err_cause_e  r_err_cause;
    logic [31:0] r_read_data;

    logic        w_start;
    logic        w_illegal;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    assign w_start      = MemRead | MemWrite;
    assign w_illegal    = (MemRead & MemWrite) | ~f3_legal(MemWrite, funct3);
    assign w_misaligned = f3_misaligned(funct3, Addr[1:0]);

    lsu_lane_align u_lane_align (
        .i_funct3 (r_funct3),
        .i_offset (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (bus.mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_load_data)
    );

    // Access FSM with latched request fields, timeout counter and registered pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= ErrNone;
            r_read_data <= 32'h0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= ErrNone;
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_we     <= MemWrite;
                        r_funct3 <= funct3;
                        r_addr   <= Addr;
                        r_wdata  <= WriteData;
                        if (w_illegal) begin
                            r_state     <= StErr;
                            r_err       <= 1'b1;
                            r_err_cause <= ErrIllegal;
                        end else if (w_misaligned) begin
                            r_state     <= StErr;
                            r_err       <= 1'b1;
                            r_err_cause <= ErrMisalign;
                        end else begin
                            r_state   <= StBusy;
                            r_cnt     <= '0;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                StBusy: begin
                    // A ready on the last count cycle still completes normally
                    if (bus.mem_ready) begin
                        r_state     <= StDone;
                        r_mem_req   <= 1'b0;
                        r_done      <= 1'b1;
                        r_read_data <= r_we ? 32'h0 : w_load_data;
                    end else if (r_cnt == CntLast) begin
                        r_state     <= StErr;
                        r_mem_req   <= 1'b0;
                        r_err       <= 1'b1;
                        r_err_cause <= ErrTimeout;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone:  r_state <= StIdle;
                StErr:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign stall     = ((r_state == StIdle) & w_start) | (r_state == StBusy);
    assign done      = r_done;
    assign err       = r_err;
    assign err_cause = r_err_cause;
    assign ReadData  = r_read_data;

    // Bus fields are forced to zero whenever no request is outstanding
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_req & r_we;
    assign bus.mem_addr  = r_mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign bus.mem_be    = r_mem_req ? w_be : 4'b0000;
    assign bus.mem_wdata = r_mem_req ? w_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives inputs and samples on the falling
// clock edge, comparing against hand-computed expectations.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned TIMEOUT_CYCLES = 16;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stall;
    logic        done;
    logic        err;
    logic [1:0]  err_cause;

    int total = 0;
    int bad   = 0;

    load_store_unit_if bus ();

    load_store_unit #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .funct3    (funct3),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .err_cause (err_cause),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present an access for one cycle; the start cycle itself must stall
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        Addr      = a;
        WriteData = wd;
        #1;
        chk("start_stall", {31'h0, stall}, 32'h1);
        chk("start_no_req", {31'h0, bus.mem_req}, 32'h0);
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        funct3        = 3'b000;
        Addr          = 32'h0;
        WriteData     = 32'h0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;

        tick();
        chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_rdata", ReadData, 32'h0);
        reset = 1'b0;
        tick();

        // LW 0x100, zero-wait
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        issue(1'b1, 1'b0, F3_LW, 32'h100, 32'h0);
        chk("lw_req", {31'h0, bus.mem_req}, 32'h1);
        chk("lw_we", {31'h0, bus.mem_we}, 32'h0);
        chk("lw_addr", bus.mem_addr, 32'h100);
        chk("lw_be", {28'h0, bus.mem_be}, 32'hF);
        chk("lw_busy_stall", {31'h0, stall}, 32'h1);
        chk("lw_busy_done", {31'h0, done}, 32'h0);
        tick();
        chk("lw_done", {31'h0, done}, 32'h1);
        chk("lw_rdata", ReadData, 32'hDEADBEEF);
        chk("lw_done_stall", {31'h0, stall}, 32'h0);
        chk("lw_done_req", {31'h0, bus.mem_req}, 32'h0);
        tick();
        chk("lw_done_pulse", {31'h0, done}, 32'h0);

        // LB / LBU at 0x103
        bus.mem_rdata = 32'h80FFFFFF;
        issue(1'b1, 1'b0, F3_LB, 32'h103, 32'h0);
        chk("lb_be", {28'h0, bus.mem_be}, 32'h8);
        chk("lb_addr", bus.mem_addr, 32'h100);
        tick();
        chk("lb_rdata", ReadData, 32'hFFFFFF80);
        tick();
        issue(1'b1, 1'b0, F3_LBU, 32'h103, 32'h0);
        tick();
        chk("lbu_rdata", ReadData, 32'h00000080);
        tick();

        // LH / LHU at 0x102
        bus.mem_rdata = 32'h80010000;
        issue(1'b1, 1'b0, F3_LH, 32'h102, 32'h0);
        chk("lh_be", {28'h0, bus.mem_be}, 32'hC);
        tick();
        chk("lh_rdata", ReadData, 32'hFFFF8001);
        tick();
        issue(1'b1, 1'b0, F3_LHU, 32'h102, 32'h0);
        tick();
        chk("lhu_rdata", ReadData, 32'h00008001);
        tick();

        // SB 0x101
        issue(1'b0, 1'b1, F3_SB, 32'h101, 32'h000000A5);
        chk("sb_we", {31'h0, bus.mem_we}, 32'h1);
        chk("sb_be", {28'h0, bus.mem_be}, 32'h2);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        tick();
        chk("sb_done", {31'h0, done}, 32'h1);
        chk("sb_rdata", ReadData, 32'h0);
        tick();

        // SH 0x202 with three wait states
        bus.mem_ready = 1'b0;
        issue(1'b0, 1'b1, F3_SH, 32'h202, 32'h1234ABCD);
        for (int i = 0; i < 4; i++) begin
            chk("sh_req", {31'h0, bus.mem_req}, 32'h1);
            chk("sh_we", {31'h0, bus.mem_we}, 32'h1);
            chk("sh_addr", bus.mem_addr, 32'h200);
            chk("sh_be", {28'h0, bus.mem_be}, 32'hC);
            chk("sh_wdata", bus.mem_wdata, 32'hABCDABCD);
            chk("sh_stall", {31'h0, stall}, 32'h1);
            chk("sh_early_done", {31'h0, done}, 32'h0);
            if (i == 3) bus.mem_ready = 1'b1;
            tick();
        end
        bus.mem_ready = 1'b0;
        chk("sh_done", {31'h0, done}, 32'h1);
        chk("sh_done_stall", {31'h0, stall}, 32'h0);
        chk("sh_rdata", ReadData, 32'h0);
        tick();

        // Misaligned LW
        issue(1'b1, 1'b0, F3_LW, 32'h101, 32'h0);
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_cause", {30'h0, err_cause}, 32'h1);
        chk("mis_req", {31'h0, bus.mem_req}, 32'h0);
        chk("mis_stall", {31'h0, stall}, 32'h0);
        chk("mis_done", {31'h0, done}, 32'h0);
        tick();
        chk("mis_err_pulse", {31'h0, err}, 32'h0);
        chk("mis_cause_clr", {30'h0, err_cause}, 32'h0);

        // Illegal store funct3, then read+write together
        issue(1'b0, 1'b1, 3'b011, 32'h300, 32'h0);
        chk("ill_err", {31'h0, err}, 32'h1);
        chk("ill_cause", {30'h0, err_cause}, 32'h2);
        chk("ill_req", {31'h0, bus.mem_req}, 32'h0);
        tick();
        issue(1'b1, 1'b1, F3_LW, 32'h300, 32'h0);
        chk("both_cause", {30'h0, err_cause}, 32'h2);
        tick();

        // Timeout: ready never arrives
        issue(1'b1, 1'b0, F3_LW, 32'h400, 32'h0);
        for (int j = 0; j < int'(TIMEOUT_CYCLES); j++) begin
            chk("to_req", {31'h0, bus.mem_req}, 32'h1);
            chk("to_no_err", {31'h0, err}, 32'h0);
            tick();
        end
        chk("to_err", {31'h0, err}, 32'h1);
        chk("to_cause", {30'h0, err_cause}, 32'h3);
        chk("to_req_drop", {31'h0, bus.mem_req}, 32'h0);
        chk("to_stall", {31'h0, stall}, 32'h0);
        tick();

        // Ready on the final count cycle completes
        bus.mem_rdata = 32'hCAFEF00D;
        issue(1'b1, 1'b0, F3_LW, 32'h404, 32'h0);
        for (int j = 0; j < int'(TIMEOUT_CYCLES); j++) begin
            if (j == int'(TIMEOUT_CYCLES) - 1) bus.mem_ready = 1'b1;
            tick();
        end
        bus.mem_ready = 1'b0;
        chk("last_done", {31'h0, done}, 32'h1);
        chk("last_no_err", {31'h0, err}, 32'h0);
        chk("last_rdata", ReadData, 32'hCAFEF00D);
        tick();

        // Reset in the middle of a BUSY access
        issue(1'b1, 1'b0, F3_LW, 32'h500, 32'h0);
        chk("mid_req", {31'h0, bus.mem_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'h0, bus.mem_req}, 32'h0);
        chk("mid_rst_stall", {31'h0, stall}, 32'h0);
        chk("mid_rst_done", {31'h0, done}, 32'h0);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h11223344;
        issue(1'b1, 1'b0, F3_LW, 32'h600, 32'h0);
        chk("post_addr", bus.mem_addr, 32'h600);
        tick();
        chk("post_done", {31'h0, done}, 32'h1);
        chk("post_rdata", ReadData, 32'h11223344);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
